regfile_write_arbiter: RTL
==========================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single register-file write port between NUM_REQ write-back sources
//  (ALU, load unit, CSR/mul unit) using round-robin arbitration.
//  Drives writeEnable/writeReg/writeData of register_file from registered outputs.
//  Also holds a pending-write scoreboard (one busy bit per architectural register).
//  Decode queries the scoreboard for RAW hazards on rs1/rs2.
// PARAMETERS
//  NUM_REQ   3   number of write-back requesters (2..8); index 0 = ALU
//  XLEN      32  data width
// PORTS
//  clk          in   1             processor clock; all state changes on posedge
//  rst_n        in   1             asynchronous active-low reset
//  reqValid     in   NUM_REQ       requester i has a write pending; held until granted
//  reqReg       in   5*NUM_REQ     destination reg of requester i, slice [5i+4:5i]
//  reqData      in   XLEN*NUM_REQ  write data of requester i, slice [XLEN*i+XLEN-1:XLEN*i]
//  reqGrant     out  NUM_REQ       one-hot, combinational: requester i accepted this cycle
//  writeEnable  out  1             registered write strobe to register file
//  writeReg     out  5             registered destination register
//  writeData    out  XLEN          registered write data
//  issueValid   in   1             decode issued an instruction that will write issueReg
//  issueReg     in   5             destination of issued instruction
//  rs1, rs2     in   5             source registers queried by decode
//  rs1Busy      out  1             scoreboard bit of rs1 (0 when rs1 = x0)
//  rs2Busy      out  1             scoreboard bit of rs2 (0 when rs2 = x0)
// BEHAVIOUR
//  Clocking: one clock; reset is asynchronous and active-low.
//  Reset values:
//   - writeEnable=0, writeReg=0, writeData=0
//   - rrPtr=0; all busy bits 0
//   - reqGrant=0 while rst_n=0
//  Arbitration:
//   - rrPtr names the highest-priority requester.
//   - Search order: rrPtr, rrPtr+1, ... mod NUM_REQ.
//   - The first valid requester in that order is granted.
//   - At most one grant per cycle. If any reqValid is set, exactly one grant.
//   - reqGrant[i] implies reqValid[i]. No grant to an invalid requester.
//  Handshake:
//   - A transfer completes on the clock edge where reqValid[i] & reqGrant[i].
//   - The requester may drop or change its request on the next cycle.
//   - A losing requester must hold reqValid/reqReg/reqData stable.
//  Pointer update:
//   - After a grant to i, rrPtr <= (i+1) mod NUM_REQ.
//   - No grant: rrPtr holds.
//   - Bound: a continuously valid requester is granted within NUM_REQ cycles.
//  Write port:
//   - Latency is 1 cycle.
//   - At the grant edge, writeReg/writeData <= the granted slices.
//   - writeEnable <= 1 only if granted reqReg != 0.
//   - A grant to x0 completes the handshake but produces writeEnable=0.
//   - No grant: writeEnable <= 0; writeReg/writeData hold.
//  Scoreboard (busy[31:1]; busy[0] is hardwired 0):
//   - set:   issueValid & issueReg!=0 -> busy[issueReg] <= 1
//   - clear: grant of reqReg=r, r!=0  -> busy[r] <= 0 at the grant edge
//   - Set and clear of the same register in the same cycle: set wins
//     (a new writer was issued).
//   - Set and clear of different registers: both apply.
//   - Clearing a non-busy register is legal and leaves it 0.
//   - rs1Busy/rs2Busy = busy[rs] combinationally from the registered bits.
//   - No same-cycle bypass of a clear.
//  Reset mid-operation:
//   - Any in-flight handshake is dropped and writeEnable falls immediately.
//   - Requesters must re-present after rst_n rises.
// TESTING
//  1. Reset: rst_n=0 with all reqValid=1
//     -> reqGrant=0, writeEnable=0, rs1Busy=rs2Busy=0.
//     Release -> first grant is requester 0.
//  2. Single request: reqValid=001, reqReg0=5, reqData0=0xDEADBEEF
//     -> reqGrant=001 same cycle.
//     Next cycle: writeEnable=1, writeReg=5, writeData=0xDEADBEEF.
//     Cycle after: writeEnable=0.
//  3. Fairness: all 3 valid for 6 cycles, each re-presenting after grant
//     -> grant order 0,1,2,0,1,2. No requester starved.
//  4. x0 write: reqValid=010, reqReg1=0
//     -> reqGrant=010, next-cycle writeEnable=0, rrPtr advances to 2.
//  5. Scoreboard: issue x7 -> rs1=7 gives rs1Busy=1 the next cycle.
//     Grant write to x7 -> rs1Busy=0 after that edge.
//     Issue x7 and grant x7 in the same cycle -> busy stays 1.
//  6. Async reset mid-write: drop rst_n between edges while writeEnable=1
//     -> writeEnable=0 immediately; all busy bits clear.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_REQ
// write-back sources, plus a per-register pending-write scoreboard for RAW checks.

module regfile_write_arbiter_sb_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic set_i,
  input  logic clr_i,
  output logic busy_o
);
  logic busy_q, busy_d;

  // A same-cycle issue means a newer writer is in flight, so set beats clear.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d = 1'b0;
    if (set_i) busy_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= 1'b0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;
endmodule

module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      reqValid,
  input  logic [5*NUM_REQ-1:0]    reqReg,
  input  logic [XLEN*NUM_REQ-1:0] reqData,
  output logic [NUM_REQ-1:0]      reqGrant,
  output logic                    writeEnable,
  output logic [4:0]              writeReg,
  output logic [XLEN-1:0]         writeData,
  input  logic                    issueValid,
  input  logic [4:0]              issueReg,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  output logic                    rs1Busy,
  output logic                    rs2Busy
);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt;
  logic               any_gnt;
  logic [4:0]         sel_reg;
  logic [XLEN-1:0]    sel_data;
  logic               wen_q;
  logic [4:0]         wreg_q;
  logic [XLEN-1:0]    wdata_q;
  logic [31:0]        busy;

  // Winner is the valid requester at the smallest rotational distance from rrPtr.
  always_comb begin
    int best, best_dist, d;
    best      = 0;
    best_dist = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = i - int'(rr_ptr_q);
      if (d < 0) d = d + NUM_REQ;
      if (reqValid[i] && d < best_dist) begin
        best_dist = d;
        best      = i;
      end
    end
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++)
      gnt[i] = rst_n && (best_dist < NUM_REQ) && (best == i);
    rr_ptr_d = rr_ptr_q;
    if (best_dist < NUM_REQ) rr_ptr_d = PW'((best + 1) % NUM_REQ);
  end

  assign any_gnt  = |gnt;
  assign reqGrant = gnt;

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_reg  = reqReg[5*i +: 5];
        sel_data = reqData[XLEN*i +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      wen_q    <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wen_q    <= any_gnt && (sel_reg != 5'd0);
      if (any_gnt) begin
        wreg_q  <= sel_reg;
        wdata_q <= sel_data;
      end
    end
  end

  assign writeEnable = wen_q;
  assign writeReg    = wreg_q;
  assign writeData   = wdata_q;

  assign busy[0] = 1'b0;
  for (genvar r = 1; r < 32; r++) begin : g_sb
    regfile_write_arbiter_sb_bit u_sb (
      .clk    (clk),
      .rst_n  (rst_n),
      .set_i  (issueValid && (issueReg == 5'(r))),
      .clr_i  (any_gnt && (sel_reg == 5'(r))),
      .busy_o (busy[r])
    );
  end

  // No bypass: a clear granted this cycle is visible only after the edge.
  assign rs1Busy = busy[rs1];
  assign rs2Busy = busy[rs2];
endmodule
